// File: rtl/matrix_alloc_manager.sv
// Shape-indexed slot allocator for the matrix memory: hands out IDs s*SLOTS+slot per m x n shape.
// Optional build macro ALLOC_EVICT_EN: full shapes reuse their oldest slot instead of rejecting.
module matrix_alloc_manager #(
    parameter int MAX_DIM = 5,
    parameter int SLOTS   = 4,
    parameter int ID_W    = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_req,
    input  logic [3:0]      alloc_m,
    input  logic [3:0]      alloc_n,
    output logic            alloc_valid,
    output logic [ID_W-1:0] alloc_id,
    output logic            alloc_err,
    output logic            alloc_evict,
    input  logic            clear_all,
    input  logic [3:0]      query_m,
    input  logic [3:0]      query_n,
    output logic [2:0]      query_count,
    output logic [ID_W-1:0] query_newest_id,
    output logic [7:0]      total_count
);

    localparam int NSHAPE = MAX_DIM * MAX_DIM;
    localparam int SW     = (NSHAPE > 1) ? $clog2(NSHAPE) : 1;
    localparam int PW     = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [2:0]      count_tbl [NSHAPE];
    logic [PW-1:0]   ptr_tbl   [NSHAPE];

    logic            a_legal;
    logic [SW-1:0]   a_s;
    logic            a_full;
    logic [ID_W-1:0] a_id;
    logic            q_legal;
    logic [SW-1:0]   q_s;
    logic [2:0]      q_count_next;
    logic [ID_W-1:0] q_newest_next;

    // Decode request and query shapes; indices are forced to 0 for illegal dims
    // so table reads never go out of range.
    always_comb begin
        a_legal = (alloc_m != 4'd0) && (alloc_m <= 4'(MAX_DIM)) &&
                  (alloc_n != 4'd0) && (alloc_n <= 4'(MAX_DIM));
        a_s = '0;
        if (a_legal)
            a_s = SW'((32'(alloc_m) - 32'd1) * MAX_DIM + (32'(alloc_n) - 32'd1));
        a_full = (count_tbl[a_s] == 3'(SLOTS));
        a_id   = ID_W'(32'(a_s) * SLOTS + 32'(ptr_tbl[a_s]));

        q_legal = (query_m != 4'd0) && (query_m <= 4'(MAX_DIM)) &&
                  (query_n != 4'd0) && (query_n <= 4'(MAX_DIM));
        q_s = '0;
        if (q_legal)
            q_s = SW'((32'(query_m) - 32'd1) * MAX_DIM + (32'(query_n) - 32'd1));
        q_count_next  = '0;
        q_newest_next = '0;
        if (q_legal && (count_tbl[q_s] != 3'd0)) begin
            q_count_next  = count_tbl[q_s];
            q_newest_next = ID_W'(32'(q_s) * SLOTS + 32'(PW'(ptr_tbl[q_s] - PW'(1))));
        end
    end

`ifdef ALLOC_EVICT_EN
    logic evict_q;
    assign alloc_evict = evict_q;
`else
    assign alloc_evict = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_valid     <= 1'b0;
            alloc_err       <= 1'b0;
            alloc_id        <= '0;
            query_count     <= '0;
            query_newest_id <= '0;
            total_count     <= '0;
`ifdef ALLOC_EVICT_EN
            evict_q         <= 1'b0;
`endif
            for (int i = 0; i < NSHAPE; i++) begin
                count_tbl[i] <= '0;
                ptr_tbl[i]   <= '0;
            end
        end else begin
            alloc_valid     <= 1'b0;
            alloc_err       <= 1'b0;
`ifdef ALLOC_EVICT_EN
            evict_q         <= 1'b0;
`endif
            query_count     <= q_count_next;
            query_newest_id <= q_newest_next;

            // Clear dominates a same-cycle request, which is then rejected.
            if (clear_all) begin
                total_count <= '0;
                for (int i = 0; i < NSHAPE; i++) begin
                    count_tbl[i] <= '0;
                    ptr_tbl[i]   <= '0;
                end
                if (alloc_req)
                    alloc_err <= 1'b1;
            end else if (alloc_req) begin
                if (!a_legal) begin
                    alloc_err <= 1'b1;
                end else if (a_full) begin
`ifdef ALLOC_EVICT_EN
                    alloc_valid    <= 1'b1;
                    evict_q        <= 1'b1;
                    alloc_id       <= a_id;
                    ptr_tbl[a_s]   <= PW'(ptr_tbl[a_s] + PW'(1));
`else
                    alloc_err      <= 1'b1;
`endif
                end else begin
                    alloc_valid    <= 1'b1;
                    alloc_id       <= a_id;
                    ptr_tbl[a_s]   <= PW'(ptr_tbl[a_s] + PW'(1));
                    count_tbl[a_s] <= count_tbl[a_s] + 3'd1;
                    total_count    <= total_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_alloc_manager.sv
// Directed self-checking bench for matrix_alloc_manager (default MAX_DIM=5, SLOTS=4, ID_W=7).
module tb_matrix_alloc_manager;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_req;
    logic [3:0] alloc_m;
    logic [3:0] alloc_n;
    logic       alloc_valid;
    logic [6:0] alloc_id;
    logic       alloc_err;
    logic       alloc_evict;
    logic       clear_all;
    logic [3:0] query_m;
    logic [3:0] query_n;
    logic [2:0] query_count;
    logic [6:0] query_newest_id;
    logic [7:0] total_count;

    int n_checks = 0;
    int n_bad    = 0;

    matrix_alloc_manager #(.MAX_DIM(5), .SLOTS(4), .ID_W(7)) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_req       (alloc_req),
        .alloc_m         (alloc_m),
        .alloc_n         (alloc_n),
        .alloc_valid     (alloc_valid),
        .alloc_id        (alloc_id),
        .alloc_err       (alloc_err),
        .alloc_evict     (alloc_evict),
        .clear_all       (clear_all),
        .query_m         (query_m),
        .query_n         (query_n),
        .query_count     (query_count),
        .query_newest_id (query_newest_id),
        .total_count     (total_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, then settle just after the rising edge.
    task automatic apply_stimulus(input logic req, input logic [3:0] m, input logic [3:0] n,
                                  input logic clr, input logic [3:0] qm, input logic [3:0] qn);
        @(negedge clk);
        alloc_req = req;
        alloc_m   = m;
        alloc_n   = n;
        clear_all = clr;
        query_m   = qm;
        query_n   = qn;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        alloc_req = 1'b0; alloc_m = '0; alloc_n = '0;
        clear_all = 1'b0; query_m = '0; query_n = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_valid", 32'(alloc_valid), 0);
        check_output("rst_err", 32'(alloc_err), 0);
        check_output("rst_evict", 32'(alloc_evict), 0);
        check_output("rst_id", 32'(alloc_id), 0);
        check_output("rst_qcount", 32'(query_count), 0);
        check_output("rst_qnewest", 32'(query_newest_id), 0);
        check_output("rst_total", 32'(total_count), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] first allocations of shape 2x3");
        apply_stimulus(1, 2, 3, 0, 2, 3);
        check_output("a23_valid", 32'(alloc_valid), 1);
        check_output("a23_err", 32'(alloc_err), 0);
        check_output("a23_id", 32'(alloc_id), 28);
        check_output("a23_total", 32'(total_count), 1);
        check_output("a23_qcount_pre", 32'(query_count), 0);
        apply_stimulus(1, 2, 3, 0, 2, 3);
        check_output("a23b_id", 32'(alloc_id), 29);
        check_output("a23b_valid", 32'(alloc_valid), 1);
        check_output("a23b_qcount", 32'(query_count), 1);
        check_output("a23b_qnewest", 32'(query_newest_id), 28);
        check_output("a23b_total", 32'(total_count), 2);

        $display("[TB] illegal dimensions");
        apply_stimulus(1, 0, 3, 0, 0, 0);
        check_output("ill03_err", 32'(alloc_err), 1);
        check_output("ill03_valid", 32'(alloc_valid), 0);
        check_output("ill03_id", 32'(alloc_id), 29);
        check_output("ill03_total", 32'(total_count), 2);
        apply_stimulus(1, 6, 1, 0, 0, 0);
        check_output("ill61_err", 32'(alloc_err), 1);
        check_output("ill61_total", 32'(total_count), 2);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("idle_err", 32'(alloc_err), 0);

        $display("[TB] filling shape 1x1 back-to-back");
        apply_stimulus(1, 1, 1, 0, 0, 0);
        check_output("f11_0_id", 32'(alloc_id), 0);
        check_output("f11_0_valid", 32'(alloc_valid), 1);
        apply_stimulus(1, 1, 1, 0, 0, 0);
        check_output("f11_1_id", 32'(alloc_id), 1);
        apply_stimulus(1, 1, 1, 0, 0, 0);
        check_output("f11_2_id", 32'(alloc_id), 2);
        apply_stimulus(1, 1, 1, 0, 0, 0);
        check_output("f11_3_id", 32'(alloc_id), 3);
        check_output("f11_3_total", 32'(total_count), 6);
        apply_stimulus(1, 1, 1, 0, 1, 1);
`ifdef ALLOC_EVICT_EN
        check_output("f11_4_valid", 32'(alloc_valid), 1);
        check_output("f11_4_evict", 32'(alloc_evict), 1);
        check_output("f11_4_id", 32'(alloc_id), 0);
`else
        check_output("f11_4_err", 32'(alloc_err), 1);
        check_output("f11_4_valid", 32'(alloc_valid), 0);
        check_output("f11_4_evict", 32'(alloc_evict), 0);
        check_output("f11_4_id", 32'(alloc_id), 3);
`endif
        check_output("f11_4_total", 32'(total_count), 6);
        apply_stimulus(0, 0, 0, 0, 1, 1);
        check_output("q11_count", 32'(query_count), 4);
`ifdef ALLOC_EVICT_EN
        check_output("q11_newest", 32'(query_newest_id), 0);
`else
        check_output("q11_newest", 32'(query_newest_id), 3);
`endif
        check_output("q11_evict_off", 32'(alloc_evict), 0);

        $display("[TB] shape 5x5 and queries");
        apply_stimulus(1, 5, 5, 0, 0, 0);
        check_output("a55_0_id", 32'(alloc_id), 96);
        apply_stimulus(1, 5, 5, 0, 0, 0);
        check_output("a55_1_id", 32'(alloc_id), 97);
        check_output("a55_total", 32'(total_count), 8);
        apply_stimulus(0, 0, 0, 0, 5, 5);
        check_output("q55_count", 32'(query_count), 2);
        check_output("q55_newest", 32'(query_newest_id), 97);
        apply_stimulus(0, 0, 0, 0, 4, 4);
        check_output("q44_count", 32'(query_count), 0);
        check_output("q44_newest", 32'(query_newest_id), 0);
        apply_stimulus(0, 0, 0, 0, 0, 5);
        check_output("q05_count", 32'(query_count), 0);

        $display("[TB] clear_all colliding with a request");
        apply_stimulus(1, 3, 3, 1, 0, 0);
        check_output("clr_err", 32'(alloc_err), 1);
        check_output("clr_valid", 32'(alloc_valid), 0);
        check_output("clr_total", 32'(total_count), 0);
        check_output("clr_id_held", 32'(alloc_id), 97);
        apply_stimulus(0, 0, 0, 0, 2, 3);
        check_output("clr_q23_count", 32'(query_count), 0);
        check_output("clr_q23_newest", 32'(query_newest_id), 0);
        apply_stimulus(1, 3, 3, 0, 0, 0);
        check_output("a33_id", 32'(alloc_id), 48);
        check_output("a33_valid", 32'(alloc_valid), 1);
        check_output("a33_total", 32'(total_count), 1);

        $display("[TB] reset during a request");
        @(negedge clk);
        alloc_req = 1'b1; alloc_m = 4'd1; alloc_n = 4'd2;
        #2;
        rst = 1'b1;
        #1;
        check_output("rstmid_async_id", 32'(alloc_id), 0);
        @(posedge clk);
        #1;
        check_output("rstmid_valid", 32'(alloc_valid), 0);
        check_output("rstmid_err", 32'(alloc_err), 0);
        check_output("rstmid_id", 32'(alloc_id), 0);
        check_output("rstmid_total", 32'(total_count), 0);
        @(negedge clk);
        rst = 1'b0;
        alloc_req = 1'b0;
        apply_stimulus(1, 1, 2, 0, 0, 0);
        check_output("a12_id", 32'(alloc_id), 4);
        check_output("a12_valid", 32'(alloc_valid), 1);
        check_output("a12_total", 32'(total_count), 1);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("pulse_width", 32'(alloc_valid), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
